// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets the CPU core (requester 0) and the DMA/hex loader
// (requester 1) share the tagged memory bus. It sequences the address, data and read-capture phases.
//
// state | meaning
// IDLE  | bus free, arbitrate between req0/req1
// ADDR  | address strobe phase
// WR    | write strobe phase, drive wdata/wtag
// RD    | read strobe phase
// WAIT  | RD_WAIT cycles of memory latency, capture on last
// DONE  | ack pulse to owner, grant held
module mem_bus_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [63:0]       wdata0,
    input  logic [63:0]       wdata1,
    input  logic [7:0]        wtag0,
    input  logic [7:0]        wtag1,
    output logic              ack0,
    output logic              ack1,
    output logic [63:0]       rdata,
    output logic [7:0]        rtag,
    output logic [1:0]        grant,
    output logic [63:0]       o_ad,
    output logic [7:0]        o_tag,
    output logic              o_astb,
    output logic              o_rd,
    output logic              o_wr,
    input  logic [63:0]       i_data,
    input  logic [7:0]        i_tag
);

    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WR,
        S_RD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             we_q;
    logic [63:0]      wdata_q;
    logic [7:0]       wtag_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pick1;

    // On a tie the requester that was not served last wins.
    assign pick1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wtag_q  <= '0;
            cnt_q   <= '0;
            grant   <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= '0;
            rtag    <= '0;
            o_ad    <= '0;
            o_tag   <= '0;
            o_astb  <= 1'b0;
            o_rd    <= 1'b0;
            o_wr    <= 1'b0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            o_astb <= 1'b0;
            o_rd   <= 1'b0;
            o_wr   <= 1'b0;
            o_ad   <= '0;
            o_tag  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        we_q    <= pick1 ? we1 : we0;
                        wdata_q <= pick1 ? wdata1 : wdata0;
                        wtag_q  <= pick1 ? wtag1 : wtag0;
                        last_q  <= pick1;
                        grant   <= pick1 ? 2'b10 : 2'b01;
                        o_astb  <= 1'b1;
                        o_ad    <= 64'(pick1 ? addr1 : addr0);
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (we_q) begin
                        o_wr    <= 1'b1;
                        o_ad    <= wdata_q;
                        o_tag   <= wtag_q;
                        state_q <= S_WR;
                    end else begin
                        o_rd    <= 1'b1;
                        state_q <= S_RD;
                    end
                end
                S_WR: begin
                    ack0    <= grant[0];
                    ack1    <= grant[1];
                    state_q <= S_DONE;
                end
                S_RD: begin
                    cnt_q   <= CNT_W'(RD_WAIT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata   <= i_data;
                        rtag    <= i_tag;
                        ack0    <= grant[0];
                        ack1    <= grant[1];
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    grant   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
